// File: rtl/axi4_pkg.sv
// AXI4 read-channel encodings and the AR/R channel bundles used by the ROM responder.
package axi4_pkg;

    localparam int AXI_ID_W = 4;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    typedef struct packed {
        logic                arvalid;
        logic [31:0]         araddr;
        logic [AXI_ID_W-1:0] arid;
        logic [7:0]          arlen;
        logic [2:0]          arsize;
        logic [1:0]          arburst;
    } ar_m;

    typedef struct packed {
        logic rready;
    } r_m;

    typedef struct packed {
        logic arready;
    } ar_s;

    typedef struct packed {
        logic                rvalid;
        logic [31:0]         rdata;
        logic [1:0]          rresp;
        logic                rlast;
        logic [AXI_ID_W-1:0] rid;
    } r_s;

endpackage

// File: rtl/riscv_pkg.sv
// Shared types for the instruction-fetch ROM responder: FSM states and buffered R beats.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DRAIN
    } rom_state_e;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rom_beat_s;

endpackage

// File: rtl/riscv_axi_burst_addr.sv
// Combinational AXI next-beat address generator; also flags unsupported burst shapes.
// WRAP bursts are honoured only when RISCV_AXI_ROM_WRAP_EN is defined.
module riscv_axi_burst_addr
    import axi4_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [7:0]  len,
    input  logic [2:0]  size,
    input  logic [1:0]  burst,
    output logic [31:0] next_addr,
    output logic        err
);

    logic [31:0] incr_addr;

    assign incr_addr = addr + (32'd1 << size);

`ifdef RISCV_AXI_ROM_WRAP_EN
    logic [31:0] wrap_mask;
    logic        wrap_len_ok;

    // Wrap window is the total burst byte count; only 2/4/8/16-beat wraps are legal.
    assign wrap_mask   = (({24'd0, len} + 32'd1) << size) - 32'd1;
    assign wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
`else
    logic unused_len;
    assign unused_len = ^len;
`endif

    always_comb begin
        next_addr = addr;
        err       = (size > 3'd2);
        case (burst)
            AXI_BURST_FIXED: next_addr = addr;
            AXI_BURST_INCR:  next_addr = incr_addr;
`ifdef RISCV_AXI_ROM_WRAP_EN
            AXI_BURST_WRAP: begin
                next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
                if (!wrap_len_ok) err = 1'b1;
            end
`else
            AXI_BURST_WRAP:  err = 1'b1;
`endif
            default:         err = 1'b1;
        endcase
    end

endmodule

// File: rtl/riscv_axi_rom_rd.sv
// AXI4 read-only ROM responder for instruction fetch: one burst at a time, 2-entry R buffer.
// Define RISCV_AXI_ROM_WRAP_EN to accept WRAP bursts (see riscv_axi_burst_addr).
module riscv_axi_rom_rd
    import axi4_pkg::*;
    import riscv_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter string       INIT_FILE   = ""
) (
    input  logic clock,
    input  logic reset,
    input  ar_m  AXI_AR_M,
    input  r_m   AXI_R_M,
    output ar_s  AXI_AR_S,
    output r_s   AXI_R_S
);

    localparam int AW = $clog2(DEPTH_WORDS);

    rom_state_e          state;
    logic                arready;
    logic [31:0]         cur_addr;
    logic [AXI_ID_W-1:0] cur_id;
    logic [7:0]          cur_len;
    logic [2:0]          cur_size;
    logic [1:0]          cur_burst;
    logic [7:0]          beat_cnt;

    logic [31:0] nxt_addr;
    logic        burst_err;

    riscv_axi_burst_addr u_burst_addr (
        .addr      (cur_addr),
        .len       (cur_len),
        .size      (cur_size),
        .burst     (cur_burst),
        .next_addr (nxt_addr),
        .err       (burst_err)
    );

    logic [31:0] mem [DEPTH_WORDS];

    initial begin
        for (int i = 0; i < DEPTH_WORDS; i++) mem[i] = 32'd0;
    end

    rom_beat_s   fifo [2];
    rom_beat_s   head;
    rom_beat_s   push_beat;
    logic        wr_ptr, rd_ptr;
    logic [1:0]  fifo_cnt;

    logic        rd_vld, rd_ok, rd_last;
    logic [1:0]  rd_resp;
    logic [31:0] rd_word;

    logic        ar_hs, pop, issue;
    logic [31:0] word_off;
    logic [1:0]  beat_resp;

    assign ar_hs    = arready & AXI_AR_M.arvalid;
    assign head     = fifo[rd_ptr];
    assign pop      = (fifo_cnt != 2'd0) & AXI_R_M.rready;
    // Counting this cycle's pop keeps one beat per cycle while never overrunning the 2 slots.
    assign issue    = (state == BURST) &&
                      (({1'b0, fifo_cnt} - {2'b0, pop} + {2'b0, rd_vld}) < 3'd2);
    assign word_off = (cur_addr - BASE_ADDR) >> 2;

    always_comb begin
        beat_resp = AXI_RESP_OKAY;
        if (burst_err)
            beat_resp = AXI_RESP_SLVERR;
        else if ((cur_addr < BASE_ADDR) || (word_off >= 32'(DEPTH_WORDS)))
            beat_resp = AXI_RESP_DECERR;
    end

    assign push_beat = '{data: rd_ok ? rd_word : 32'd0, resp: rd_resp, last: rd_last};

    always_ff @(posedge clock) begin
        if (issue) rd_word <= mem[word_off[AW-1:0]];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            arready   <= 1'b0;
            cur_addr  <= '0;
            cur_id    <= '0;
            cur_len   <= '0;
            cur_size  <= '0;
            cur_burst <= '0;
            beat_cnt  <= '0;
            rd_vld    <= 1'b0;
            rd_ok     <= 1'b0;
            rd_resp   <= '0;
            rd_last   <= 1'b0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            fifo_cnt  <= '0;
            fifo[0]   <= '0;
            fifo[1]   <= '0;
        end else begin
            rd_vld <= issue;
            if (issue) begin
                rd_ok    <= (beat_resp == AXI_RESP_OKAY);
                rd_resp  <= beat_resp;
                rd_last  <= (beat_cnt == 8'd0);
                cur_addr <= nxt_addr;
                beat_cnt <= beat_cnt - 8'd1;
            end
            if (rd_vld) begin
                fifo[wr_ptr] <= push_beat;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_cnt + {1'b0, rd_vld} - {1'b0, pop};

            case (state)
                IDLE: begin
                    arready <= 1'b1;
                    if (ar_hs) begin
                        arready   <= 1'b0;
                        cur_addr  <= AXI_AR_M.araddr;
                        cur_id    <= AXI_AR_M.arid;
                        cur_len   <= AXI_AR_M.arlen;
                        cur_size  <= AXI_AR_M.arsize;
                        cur_burst <= AXI_AR_M.arburst;
                        beat_cnt  <= AXI_AR_M.arlen;
                        state     <= BURST;
                    end
                end
                BURST: if (issue && beat_cnt == 8'd0) state <= DRAIN;
                DRAIN: begin
                    if (pop && head.last) begin
                        arready <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign AXI_AR_S = '{arready: arready};
    assign AXI_R_S  = '{rvalid: (fifo_cnt != 2'd0), rdata: head.data, rresp: head.resp,
                        rlast: head.last, rid: cur_id};

endmodule

// File: tb/tb_riscv_axi_rom_rd.sv
// Directed bench for riscv_axi_rom_rd: latency, bursts, backpressure, decode errors, wrap, reset.
module tb_riscv_axi_rom_rd;
    import axi4_pkg::*;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 64;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  r;
        logic        l;
        logic [3:0]  id;
        int          hs_cyc;
    } beat_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    ar_m  ar;
    r_m   rm;
    ar_s  ars;
    r_s   rs;

    int    n_vec = 0, n_err = 0, cyc = 0;
    int    ar_edge = 0, first_hs = 0, last_hs = 0, last_rlast_cyc = 0;
    beat_t got_q[$], exp_q[$];
    bit    toggle = 1'b0, stall_pend = 1'b0;
    logic [31:0] stall_d = '0;

    riscv_axi_rom_rd #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .INIT_FILE("")) dut (
        .clock    (clock),
        .reset    (reset),
        .AXI_AR_M (ar),
        .AXI_R_M  (rm),
        .AXI_AR_S (ars),
        .AXI_R_S  (rs)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    function automatic logic [31:0] wv(input int i);
        return (i == 0) ? 32'h0000_0013 : (32'hA5A5_0000 | 32'(i));
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Handshake recorder plus the AXI hold rule on stalled beats.
    always @(negedge clock) begin
        if (reset && stall_pend) begin
            chk("hold_valid", 32'(rs.rvalid), 32'd1);
            chk("hold_data", rs.rdata, stall_d);
        end
        stall_pend = reset && rs.rvalid && !rm.rready;
        stall_d    = rs.rdata;
        if (reset && rs.rvalid && rm.rready) begin
            got_q.push_back('{d: rs.rdata, r: rs.rresp, l: rs.rlast, id: rs.rid, hs_cyc: cyc + 1});
            if (rs.rlast) last_rlast_cyc = cyc + 1;
        end
    end

    task automatic push_exp(input logic [31:0] d, input logic [1:0] r, input logic l, input logic [3:0] id);
        exp_q.push_back('{d: d, r: r, l: l, id: id, hs_cyc: 0});
    endtask

    task automatic send_ar(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                           input logic [2:0] sz, input logic [1:0] bt);
        bit hs = 1'b0;
        ar.araddr = a; ar.arid = id; ar.arlen = len; ar.arsize = sz; ar.arburst = bt;
        ar.arvalid = 1'b1;
        for (int i = 0; i < 64 && !hs; i++) begin
            @(negedge clock); hs = ars.arready;
            @(posedge clock); #1;
        end
        ar.arvalid = 1'b0;
        ar_edge = cyc;
        chk("ar_handshake", 32'(hs), 32'd1);
    endtask

    task automatic expect_beats(input string tag, input int n);
        beat_t g, e;
        int t = 0;
        while (got_q.size() < n && t < 300) begin
            @(posedge clock); #1; t++;
            if (toggle) rm.rready = ~rm.rready;
        end
        chk({tag, "_count"}, 32'(got_q.size()), 32'(n));
        if (got_q.size() >= n) begin
            first_hs = got_q[0].hs_cyc;
            last_hs  = got_q[n-1].hs_cyc;
        end
        for (int i = 0; i < n; i++) begin
            if (got_q.size() == 0 || exp_q.size() == 0) break;
            g = got_q.pop_front();
            e = exp_q.pop_front();
            chk($sformatf("%s_data%0d", tag, i), g.d, e.d);
            chk($sformatf("%s_resp%0d", tag, i), 32'(g.r), 32'(e.r));
            chk($sformatf("%s_last%0d", tag, i), 32'(g.l), 32'(e.l));
            chk($sformatf("%s_id%0d", tag, i), 32'(g.id), 32'(e.id));
        end
        exp_q.delete();
        repeat (3) begin
            @(posedge clock); #1;
            if (toggle) rm.rready = ~rm.rready;
        end
        chk({tag, "_extra"}, 32'(got_q.size()), 32'd0);
        got_q.delete();
    endtask

    initial begin
        ar = '0;
        rm = '0;
        #1;
        for (int i = 0; i < DEPTH; i++) dut.mem[i] = wv(i);
        repeat (3) @(negedge clock);
        reset = 1'b1; #1;
        chk("rst_arready", 32'(ars.arready), 32'd0);
        chk("rst_rvalid", 32'(rs.rvalid), 32'd0);
        chk("rst_rdata", rs.rdata, 32'd0);
        chk("rst_rresp", 32'(rs.rresp), 32'd0);
        chk("rst_rlast", 32'(rs.rlast), 32'd0);
        chk("rst_rid", 32'(rs.rid), 32'd0);
        @(posedge clock); #1;
        chk("arready_1st_edge", 32'(ars.arready), 32'd1);

        // single beat latency
        rm.rready = 1'b1;
        push_exp(32'h13, AXI_RESP_OKAY, 1'b1, 4'd5);
        send_ar(BASE, 4'd5, 8'd0, 3'd2, AXI_BURST_INCR);
        @(posedge clock); #1;
        chk("t1_rvalid_n1", 32'(rs.rvalid), 32'd0);
        @(posedge clock); #1;
        chk("t1_rvalid_n2", 32'(rs.rvalid), 32'd1);
        chk("t1_rdata", rs.rdata, 32'h0000_0013);
        chk("t1_rresp", 32'(rs.rresp), 32'd0);
        chk("t1_rlast", 32'(rs.rlast), 32'd1);
        chk("t1_rid", 32'(rs.rid), 32'd5);
        expect_beats("t1", 1);

        // INCR x8 streaming, then with rready toggling
        for (int i = 0; i < 8; i++) push_exp(wv(8 + i), AXI_RESP_OKAY, 1'(i == 7), 4'd3);
        send_ar(BASE + 32'h20, 4'd3, 8'd7, 3'd2, AXI_BURST_INCR);
        expect_beats("t2", 8);
        chk("t2_first_hs", 32'(first_hs), 32'(ar_edge + 3));
        chk("t2_last_hs", 32'(last_hs), 32'(ar_edge + 10));
        rm.rready = 1'b0;
        for (int i = 0; i < 8; i++) push_exp(wv(8 + i), AXI_RESP_OKAY, 1'(i == 7), 4'd3);
        send_ar(BASE + 32'h20, 4'd3, 8'd7, 3'd2, AXI_BURST_INCR);
        toggle = 1'b1;
        expect_beats("t2t", 8);
        toggle = 1'b0;
        rm.rready = 1'b1;

        // end of array, bad size, below base, reserved burst
        for (int i = 0; i < 4; i++)
            push_exp(i < 2 ? wv(62 + i) : 32'd0, i < 2 ? AXI_RESP_OKAY : AXI_RESP_DECERR, 1'(i == 3), 4'd1);
        send_ar(BASE + 32'(DEPTH * 4) - 32'd8, 4'd1, 8'd3, 3'd2, AXI_BURST_INCR);
        expect_beats("t3", 4);
        for (int i = 0; i < 4; i++) push_exp(32'd0, AXI_RESP_SLVERR, 1'(i == 3), 4'd2);
        send_ar(BASE + 32'(DEPTH * 4) - 32'd8, 4'd2, 8'd3, 3'd3, AXI_BURST_INCR);
        expect_beats("t3s", 4);
        push_exp(32'd0, AXI_RESP_DECERR, 1'b0, 4'd4);
        push_exp(32'h13, AXI_RESP_OKAY, 1'b1, 4'd4);
        send_ar(BASE - 32'd4, 4'd4, 8'd1, 3'd2, AXI_BURST_INCR);
        expect_beats("t3b", 2);
        for (int i = 0; i < 2; i++) push_exp(32'd0, AXI_RESP_SLVERR, 1'(i == 1), 4'd7);
        send_ar(BASE, 4'd7, 8'd1, 3'd2, 2'b11);
        expect_beats("t3r", 2);

        // WRAP
`ifdef RISCV_AXI_ROM_WRAP_EN
        push_exp(wv(6), AXI_RESP_OKAY, 1'b0, 4'd8);
        push_exp(wv(7), AXI_RESP_OKAY, 1'b0, 4'd8);
        push_exp(wv(4), AXI_RESP_OKAY, 1'b0, 4'd8);
        push_exp(wv(5), AXI_RESP_OKAY, 1'b1, 4'd8);
`else
        for (int i = 0; i < 4; i++) push_exp(32'd0, AXI_RESP_SLVERR, 1'(i == 3), 4'd8);
`endif
        send_ar(BASE + 32'h18, 4'd8, 8'd3, 3'd2, AXI_BURST_WRAP);
        expect_beats("t4", 4);
        for (int i = 0; i < 3; i++) push_exp(32'd0, AXI_RESP_SLVERR, 1'(i == 2), 4'd10);
        send_ar(BASE + 32'h18, 4'd10, 8'd2, 3'd2, AXI_BURST_WRAP);
        expect_beats("t4l", 3);

        // FIXED with a second AR waiting behind it
        rm.rready = 1'b0;
        for (int i = 0; i < 4; i++) push_exp(wv(1), AXI_RESP_OKAY, 1'(i == 3), 4'd6);
        push_exp(wv(2), AXI_RESP_OKAY, 1'b1, 4'd9);
        send_ar(BASE + 32'd4, 4'd6, 8'd3, 3'd2, AXI_BURST_FIXED);
        ar.araddr = BASE + 32'd8; ar.arid = 4'd9; ar.arlen = 8'd0; ar.arsize = 3'd2;
        ar.arburst = AXI_BURST_INCR; ar.arvalid = 1'b1;
        repeat (3) begin @(posedge clock); #1; end
        chk("t5_arready_held", 32'(ars.arready), 32'd0);
        rm.rready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (ars.arready) break;
        end
        chk("t5_arready_rise", 32'(cyc), 32'(last_rlast_cyc));
        send_ar(BASE + 32'd8, 4'd9, 8'd0, 3'd2, AXI_BURST_INCR);
        chk("t5_ar2_edge", 32'(ar_edge), 32'(last_rlast_cyc + 1));
        expect_beats("t5", 5);

        // reset in the middle of a stalled burst
        rm.rready = 1'b0;
        send_ar(BASE, 4'd3, 8'd7, 3'd2, AXI_BURST_INCR);
        repeat (4) begin @(posedge clock); #1; end
        chk("t6_rvalid_pre", 32'(rs.rvalid), 32'd1);
        @(negedge clock); #1;
        reset = 1'b0; #1;
        chk("t6_rvalid_async", 32'(rs.rvalid), 32'd0);
        chk("t6_arready_rst", 32'(ars.arready), 32'd0);
        repeat (2) @(posedge clock);
        #1; rm.rready = 1'b1;
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1;
        chk("t6_arready_1st", 32'(ars.arready), 32'd1);
        repeat (20) begin @(posedge clock); #1; end
        chk("t6_stale_beats", 32'(got_q.size()), 32'd0);
        chk("t6_rvalid_idle", 32'(rs.rvalid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
